apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The parameter list SHALL be: TIMEOUT, 255, max ACCESS-phase wait cycles before abort.
REQ-002 The clock SHALL be: PCLK  in  1  system clock, all state on rising edge.
REQ-003 The reset SHALL be: PRESET  in  1  asynchronous, active-high reset.
REQ-004 The core request ports SHALL be: transfer  in  1  single-cycle request strobe; write  in  1  1=write, 0=read; addr  in  32  byte address; wdata  in  32  write data.
REQ-005 The core response ports SHALL be: rdata  out  32  read data; ready  out  1  one-cycle completion pulse; err  out  1  error flag, valid only with ready.
REQ-006 The APB output ports SHALL be: PADDR  out  32; PWDATA  out  32; PWRITE  out  1; PENABLE  out  1; PSEL  out  4  one-hot slave select.
REQ-007 The APB input ports SHALL be: PRDATA0..PRDATA3  in  32 each; PREADY0..PREADY3  in  1 each, one pair per slave.

Function
REQ-008 The address map SHALL be: slave i occupies 0x1000_0000 + i*0x1000 .. +0xFFF for i=0..3, decoded on addr[31:12]; any other address is unmapped.
REQ-009 The FSM SHALL have the states IDLE, SETUP, ACCESS and ERROR.
REQ-010 transfer SHALL be sampled only in IDLE; in every other state it is ignored and no request is queued.
REQ-011 In IDLE with transfer=1 and a mapped addr, the block SHALL register addr, wdata, write and the one-hot select, then go to SETUP.
REQ-012 In IDLE with transfer=1 and an unmapped addr, the block SHALL go to ERROR with PSEL remaining 0.
REQ-013 In SETUP, the block SHALL drive PSEL[i]=1 and PENABLE=0, then go to ACCESS unconditionally after one cycle.
REQ-014 In ACCESS, the block SHALL drive PSEL[i]=1 and PENABLE=1, holding PADDR, PWDATA and PWRITE stable.
REQ-015 When the selected PREADYi=1 in ACCESS, the block SHALL assert ready=1 and err=0 in that same cycle, drive rdata=PRDATAi (0 on writes) combinationally, and return to IDLE.
REQ-016 PREADY and PRDATA of non-selected slaves SHALL have no effect on any output.
REQ-017 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADYi=0.
REQ-018 When the wait counter equals TIMEOUT with PREADYi=0, the block SHALL assert ready=1, err=1 and rdata=0, and return to IDLE, dropping PSEL and PENABLE on the next edge.
REQ-019 ERROR SHALL last exactly one cycle, with ready=1, err=1 and rdata=0, then return to IDLE.
REQ-020 Minimum latency SHALL be: transfer at edge N gives SETUP in cycle N+1, ACCESS in N+2, and the earliest ready in N+2 (zero wait states).
REQ-021 Outside a completion cycle, ready, err and rdata SHALL be 0.
REQ-022 PENABLE=1 SHALL occur only when PSEL is nonzero, and at most one bit of PSEL SHALL be 1 at any time.
REQ-023 A new transfer SHALL be acceptable in the IDLE cycle that directly follows completion (back-to-back, one IDLE gap).

Reset
REQ-024 On PRESET=1, the block SHALL go to IDLE asynchronously, including mid-SETUP or mid-ACCESS, and the interrupted transfer SHALL get no ready.
REQ-025 During and after reset, the block SHALL drive PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, ready=0, err=0, rdata=0, and clear the wait counter.

Structure
REQ-026 Package apb_pkg SHALL hold the state enum, NUM_SLAVES=4, the base address 0x1000_0000, the region size 0x1000 and the select width.
REQ-027 The combinational sub-module apb_addr_decoder SHALL map addr to a one-hot select and a mapped flag.
REQ-028 The FSM, the address/data registers, the wait counter and the PRDATA/PREADY mux SHALL reside in apb_master.

Verification
REQ-029 Write addr=0x1000_0000, wdata=0x5, PREADY0 tied 1 -> cycle N+1 PSEL=0001/PENABLE=0; N+2 PENABLE=1, PWDATA=0x5, ready=1, err=0.
REQ-030 Read addr=0x1000_2008, PREADY2 low for 3 ACCESS cycles, PRDATA2=0xDEAD_BEEF -> PSEL=0100, PADDR=0x1000_2008 stable, ready=1 with rdata=0xDEAD_BEEF in the 4th ACCESS cycle.
REQ-031 Read addr=0x2000_0000 -> PSEL stays 0000, ready=1 and err=1 in cycle N+1, rdata=0.
REQ-032 Read slave 1, PREADY1 never set, TIMEOUT=255 -> ready=1, err=1 after 255 ACCESS wait cycles, then PSEL=0000.
REQ-033 PRESET pulsed during ACCESS of a write to slave 3 -> PSEL=0000 and PENABLE=0 immediately, no ready; a subsequent write to slave 0 completes normally.
REQ-034 transfer pulsed during SETUP and again on the IDLE cycle after completion -> the first pulse is ignored and the second starts a new transfer.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and address-map constants for the APB master and its decoder.
package apb_pkg;
   localparam int          NUM_SLAVES  = 4;
   localparam int          SEL_W       = NUM_SLAVES;
   localparam logic [31:0] BASE_ADDR   = 32'h1000_0000;
   localparam logic [31:0] REGION_SIZE = 32'h0000_1000;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERROR} state_t;

   // 4 KB page number (addr[31:12]) owned by slave idx
   function automatic logic [19:0] slave_page(input int idx);
      logic [31:0] base;
      base = BASE_ADDR + REGION_SIZE * 32'(idx);
      return base[31:12];
   endfunction
endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a byte address onto a one-hot slave select plus a mapped flag.
module apb_addr_decoder
   import apb_pkg::*;
(
   input  logic [31:0]      addr,
   output logic [SEL_W-1:0] sel,
   output logic             mapped
);

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         sel[i] = (addr[31:12] == slave_page(i));
      mapped = |sel;
   end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: core request -> SETUP/ACCESS with timeout,
// unmapped addresses answered by a one-cycle ERROR completion.
module apb_master
   import apb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic             transfer,
   input  logic             write,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             ready,
   output logic             err,
   output logic [31:0]      PADDR,
   output logic [31:0]      PWDATA,
   output logic             PWRITE,
   output logic             PENABLE,
   output logic [SEL_W-1:0] PSEL,
   input  logic [31:0]      PRDATA0,
   input  logic [31:0]      PRDATA1,
   input  logic [31:0]      PRDATA2,
   input  logic [31:0]      PRDATA3,
   input  logic             PREADY0,
   input  logic             PREADY1,
   input  logic             PREADY2,
   input  logic             PREADY3
);

   localparam int               CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_t                           state, next_state;
   logic [SEL_W-1:0]                 sel_q, dec_sel;
   logic                             dec_mapped;
   logic [CNT_W-1:0]                 wait_cnt;
   logic [NUM_SLAVES-1:0][31:0]      prdata;
   logic [NUM_SLAVES-1:0]            pready_vec;
   logic                             sel_ready;
   logic [31:0]                      sel_rdata;

   assign prdata     = {PRDATA3, PRDATA2, PRDATA1, PRDATA0};
   assign pready_vec = {PREADY3, PREADY2, PREADY1, PREADY0};

   apb_addr_decoder u_dec (
      .addr   (addr),
      .sel    (dec_sel),
      .mapped (dec_mapped)
   );

   // sel_q is one-hot, so an OR-mux keeps non-selected slaves out
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) begin
            sel_ready = sel_ready | pready_vec[i];
            sel_rdata = sel_rdata | prdata[i];
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state    <= IDLE;
         PADDR    <= '0;
         PWDATA   <= '0;
         PWRITE   <= 1'b0;
         sel_q    <= '0;
         wait_cnt <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && transfer && dec_mapped) begin
            PADDR  <= addr;
            PWDATA <= wdata;
            PWRITE <= write;
            sel_q  <= dec_sel;
         end
         if (state == ACCESS && next_state == ACCESS)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
      end
   end

   always_comb begin
      next_state = state;
      ready      = 1'b0;
      err        = 1'b0;
      rdata      = '0;
      PSEL       = '0;
      PENABLE    = 1'b0;
      case (state)
         IDLE: begin
            if (transfer) next_state = dec_mapped ? SETUP : ERROR;
         end
         SETUP: begin
            PSEL       = sel_q;
            next_state = ACCESS;
         end
         ACCESS: begin
            PSEL    = sel_q;
            PENABLE = 1'b1;
            if (sel_ready) begin
               ready      = 1'b1;
               rdata      = PWRITE ? '0 : sel_rdata;
               next_state = IDLE;
            end else if (wait_cnt == CNT_MAX) begin
               ready      = 1'b1;
               err        = 1'b1;
               next_state = IDLE;
            end
         end
         ERROR: begin
            ready      = 1'b1;
            err        = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: directed transfers push expected completions,
// a negedge monitor pops and compares them whenever ready is seen.
module tb_apb_master;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        transfer = 1'b0;
   logic        write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ready, err;
   logic [31:0] PADDR, PWDATA;
   logic        PWRITE, PENABLE;
   logic [3:0]  PSEL;
   logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
   logic        PREADY0, PREADY1, PREADY2, PREADY3;

   int          checks = 0;
   int          errors = 0;
   resp_t       scb[$];

   // simple slave model: PREADYi rises after wait_req[i] ACCESS cycles
   int          wait_req[4] = '{0, 0, 0, 0};
   logic [3:0]  force_rdy = 4'b0001;
   int          acc_cnt;

   assign PRDATA0 = 32'h0000_AAAA;
   assign PRDATA1 = 32'h1111_1111;
   assign PRDATA2 = 32'hDEAD_BEEF;
   assign PRDATA3 = 32'h3333_CAFE;
   assign PREADY0 = force_rdy[0] | (PSEL[0] && PENABLE && acc_cnt >= wait_req[0]);
   assign PREADY1 = force_rdy[1] | (PSEL[1] && PENABLE && acc_cnt >= wait_req[1]);
   assign PREADY2 = force_rdy[2] | (PSEL[2] && PENABLE && acc_cnt >= wait_req[2]);
   assign PREADY3 = force_rdy[3] | (PSEL[3] && PENABLE && acc_cnt >= wait_req[3]);

   always @(posedge PCLK or posedge PRESET) begin
      if (PRESET) acc_cnt <= 0;
      else if (PENABLE && !ready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   always #5 PCLK = ~PCLK;

   apb_master #(.TIMEOUT(255)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL),
      .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
      .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: completion checks against the scoreboard plus bus invariants
   always @(negedge PCLK) begin
      resp_t e;
      if (!PRESET) begin
         chk("psel_onehot0", 32'($onehot0(PSEL)), 32'd1);
         chk("penable_without_psel", 32'(PENABLE && PSEL == 4'b0), 32'd0);
         if (ready) begin
            if (scb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready actual=1 expected=0 at %0t", $time);
            end else begin
               e = scb.pop_front();
               chk("resp_rdata", rdata, e.rdata);
               chk("resp_err", 32'(err), 32'(e.err));
            end
         end else begin
            chk("idle_rdata", rdata, 32'h0);
            chk("idle_err", 32'(err), 32'h0);
         end
      end
   end

   // One transfer; sel=0 means the address is expected to be unmapped.
   // pulse keeps transfer high through SETUP with a different address.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] sel, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat, input bit pulse);
      int lat = 0;
      bit done = 0;
      scb.push_back('{rdata: exp_rd, err: exp_err});
      write = wr; addr = a; wdata = d; transfer = 1'b1;
      @(posedge PCLK); #1;
      if (pulse) addr = 32'h3000_0000;
      else transfer = 1'b0;
      while (!done && lat < exp_lat + 8) begin
         @(negedge PCLK);
         lat++;
         if (pulse && lat == 2) transfer = 1'b0;
         if (sel == 4'b0) begin
            chk("unmapped_psel", 32'(PSEL), 32'h0);
         end else if (lat == 1) begin
            chk("setup_psel", 32'(PSEL), 32'(sel));
            chk("setup_penable", 32'(PENABLE), 32'h0);
         end else begin
            chk("access_psel", 32'(PSEL), 32'(sel));
            chk("access_penable", 32'(PENABLE), 32'h1);
            chk("access_paddr", PADDR, a);
            chk("access_pwrite", 32'(PWRITE), 32'(wr));
            chk("access_pwdata", PWDATA, d);
         end
         if (ready) done = 1;
      end
      chk("latency", done ? lat : -1, exp_lat);
      @(posedge PCLK); #1;
      chk("after_psel", 32'(PSEL), 32'h0);
      chk("after_penable", 32'(PENABLE), 32'h0);
      chk("after_ready", 32'(ready), 32'h0);
   endtask

   initial begin
      #1;
      chk("rst_psel", 32'(PSEL), 32'h0);
      chk("rst_penable", 32'(PENABLE), 32'h0);
      chk("rst_pwrite", 32'(PWRITE), 32'h0);
      chk("rst_paddr", PADDR, 32'h0);
      chk("rst_pwdata", PWDATA, 32'h0);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      repeat (2) @(negedge PCLK);
      PRESET = 1'b0;
      @(posedge PCLK); #1;

      xfer(1'b1, 32'h1000_0000, 32'h0000_0005, 4'b0001, 32'h0, 1'b0, 2, 0);
      wait_req[2] = 3;
      xfer(1'b0, 32'h1000_2008, 32'h0, 4'b0100, 32'hDEAD_BEEF, 1'b0, 5, 0);
      xfer(1'b0, 32'h2000_0000, 32'h0, 4'b0000, 32'h0, 1'b1, 1, 0);

      // timeout on slave 1 while every other slave reports ready
      force_rdy = 4'b1101;
      wait_req[1] = 100000;
      xfer(1'b0, 32'h1000_1004, 32'h0, 4'b0010, 32'h0, 1'b1, 257, 0);
      force_rdy = 4'b0001;

      // reset in the middle of ACCESS of a write to slave 3
      wait_req[3] = 1000;
      write = 1'b1; addr = 32'h1000_3000; wdata = 32'h3030_3030; transfer = 1'b1;
      @(posedge PCLK); #1;
      transfer = 1'b0;
      repeat (2) @(negedge PCLK);
      chk("pre_rst_psel", 32'(PSEL), 32'h8);
      chk("pre_rst_penable", 32'(PENABLE), 32'h1);
      PRESET = 1'b1;
      #1;
      chk("midrst_psel", 32'(PSEL), 32'h0);
      chk("midrst_penable", 32'(PENABLE), 32'h0);
      chk("midrst_ready", 32'(ready), 32'h0);
      chk("midrst_paddr", PADDR, 32'h0);
      chk("midrst_pwdata", PWDATA, 32'h0);
      chk("midrst_pwrite", 32'(PWRITE), 32'h0);
      repeat (2) @(negedge PCLK);
      PRESET = 1'b0;
      wait_req[3] = 0;
      @(posedge PCLK); #1;
      chk("postrst_psel", 32'(PSEL), 32'h0);

      xfer(1'b1, 32'h1000_0010, 32'hA5A5_0001, 4'b0001, 32'h0, 1'b0, 2, 0);

      // transfer held through SETUP is ignored; back-to-back follows
      xfer(1'b0, 32'h1000_3FFC, 32'h0, 4'b1000, 32'h3333_CAFE, 1'b0, 2, 1);
      wait_req[2] = 1;
      xfer(1'b0, 32'h1000_2000, 32'h0, 4'b0100, 32'hDEAD_BEEF, 1'b0, 3, 0);
      xfer(1'b1, 32'h1000_2FFF, 32'h1234_5678, 4'b0100, 32'h0, 1'b0, 3, 0);

      xfer(1'b0, 32'h1000_4000, 32'h0, 4'b0000, 32'h0, 1'b1, 1, 0);
      xfer(1'b0, 32'h0FFF_FFFC, 32'h0, 4'b0000, 32'h0, 1'b1, 1, 0);
      xfer(1'b0, 32'h1000_3FFF, 32'h0, 4'b1000, 32'h3333_CAFE, 1'b0, 2, 0);

      repeat (3) @(negedge PCLK);
      chk("scoreboard_drained", scb.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
